rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Writer side of the instruction ROM write port: receives a byte stream from the host link (UART/debug RX),
//  assembles big-endian 32-bit instruction words, drives w_rom_data/w_rom_addr/en_w_rom with consecutive addresses.
//  Holds the CPU while loading and reports done/error. Sits between the host RX block and the ROM.
// PARAMETERS
//  ADDR_W       16        width of w_rom_addr and the word-count header
//  MAX_WORDS    1024      largest accepted word count (ROM depth); header count > MAX_WORDS -> error
//  TIMEOUT_CYC  100000    idle cycles allowed between accepted bytes during a load before error
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       reset, asynchronous, active-low
//  start_i      in   1       1-cycle pulse: arm a new load
//  rx_data_i    in   8       incoming byte
//  rx_valid_i   in   1       rx_data_i valid
//  rx_ready_o   out  1       loader can accept a byte; transfer when rx_valid_i & rx_ready_o
//  w_rom_data   out  32      instruction word to ROM
//  w_rom_addr   out  ADDR_W  ROM word address
//  en_w_rom     out  1       ROM write enable, active-high, exactly 1 cycle per word
//  cpu_hold_o   out  1       stall CPU/PC while loading (= busy)
//  done_o       out  1       load completed OK; held until next start_i
//  err_o        out  1       load failed; held until next start_i
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: all outputs 0, state IDLE, counters 0; applies immediately mid-load (en_w_rom drops at once; partially written ROM is not restored).
//  Frame: LEN_HI, LEN_LO (word count N, big-endian), then N*4 payload bytes, MSB of each word first.
//  FSM: IDLE -start_i-> LEN_HI -> LEN_LO -> (N==0: DONE | N>MAX_WORDS: ERR | else DATA)
//   DATA: accept 4 bytes into shift register -> WRITE
//   WRITE: 1 cycle, en_w_rom=1, w_rom_addr=word index, w_rom_data=assembled word; rx_ready_o=0;
//     index+1; index==N -> DONE (or CHK with option) else DATA.
//   DONE/ERR: sticky; start_i -> LEN_HI, clears done_o/err_o same edge.
//  rx_ready_o=1 only in LEN_HI, LEN_LO, DATA (and CHK); 0 in IDLE/WRITE/DONE/ERR; bytes offered then are not consumed.
//  start_i while in LEN_HI..WRITE/CHK ignored. start_i and rx_valid_i same cycle in IDLE: byte not consumed.
//  Latency: 4th byte accepted at edge k -> en_w_rom high during cycle k+1; peak rate 1 word / 5 cycles.
//  w_rom_addr/w_rom_data hold last written values outside WRITE; en_w_rom=0 outside WRITE.
//  cpu_hold_o=1 in every state except IDLE/DONE/ERR.
//  Timeout: counter cleared on each accepted byte and on entering LEN_HI; counts in LEN_HI..CHK except WRITE;
//   reaches TIMEOUT_CYC -> ERR. No wrap: word index width ADDR_W, N<=MAX_WORDS guarantees no overflow.
// CONFIGURATION
//  ROM_LOADER_CHECKSUM_EN defined: after last WRITE enter CHK, accept 1 byte; must equal 8-bit sum (mod 256)
//   of all payload bytes (header excluded) -> DONE, else ERR. N==0 also goes via CHK (expected 8'h00).
//  Undefined: no CHK state, no checksum logic; last WRITE -> DONE directly.
// TESTING
//  Reset mid-load: assert rst_i low during DATA -> en_w_rom, rx_ready_o, cpu_hold_o, done_o, err_o all 0 asynchronously; state IDLE.
//  Load N=2: start_i, 00 02 DE AD BE EF 01 23 45 67 -> writes 0xDEADBEEF@0, 0x01234567@1, one en_w_rom pulse each, done_o=1, cpu_hold_o=0.
//  Header 00 00 -> done_o=1, no en_w_rom pulse; header count MAX_WORDS+1 -> err_o=1, no write.
//  Backpressure: rx_valid_i held high continuously -> rx_ready_o low in each WRITE cycle, no byte lost, 5 cycles/word.
//  Timeout: stop sending after 3 payload bytes -> err_o=1 exactly TIMEOUT_CYC cycles after last accepted byte, no write.
//  Checksum (option on): N=1, AA BB CC DD, chk 0x0E -> done_o; chk 0x0F -> err_o (word still written at address 0).

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: assembles big-endian 32-bit words from a host byte stream and writes them to the instruction ROM.
// Optional trailing checksum byte: define ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
    parameter int ADDR_W      = 16,
    parameter int MAX_WORDS   = 1024,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [31:0]       w_rom_data,
    output logic [ADDR_W-1:0] w_rom_addr,
    output logic              en_w_rom,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

`ifdef ROM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DATA = 3'd3,
        S_WRITE = 3'd4, S_DONE = 3'd5, S_ERR = 3'd6, S_CHK = 3'd7
    } state_t;
    localparam state_t S_FINAL = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DATA = 3'd3,
        S_WRITE = 3'd4, S_DONE = 3'd5, S_ERR = 3'd6
    } state_t;
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q;
    logic [ADDR_W-1:0] len_q, idx_q, w_rom_addr_q;
    logic [23:0]       shift_q;
    logic [1:0]        byte_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [31:0]       w_rom_data_q;
    logic              rx_ready_q, en_w_rom_q, cpu_hold_q, done_q, err_q;
    logic              ready_d, hold_d;
    logic              accept_s, timeout_s;
    logic [15:0]       hdr_s;
    logic [ADDR_W-1:0] idx_inc_s;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    // Handshake, timeout detect and helper arithmetic
    always_comb begin
        accept_s  = rx_valid_i & rx_ready_q;
        timeout_s = ~accept_s & (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
        hdr_s     = {len_hi_q, rx_data_i};
        idx_inc_s = idx_q + ADDR_W'(1);
    end

    // Next-state decode and the output levels that follow from it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) state_d = S_LEN_HI;
                else         state_d = state_q;
            end
            S_LEN_HI: begin
                if (accept_s)       state_d = S_LEN_LO;
                else if (timeout_s) state_d = S_ERR;
                else                state_d = S_LEN_HI;
            end
            S_LEN_LO: begin
                if (accept_s) begin
                    if (hdr_s == 16'd0)                 state_d = S_FINAL;
                    else if (hdr_s > 16'(MAX_WORDS))    state_d = S_ERR;
                    else                                state_d = S_DATA;
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    if (byte_cnt_q == 2'd3) state_d = S_WRITE;
                    else                    state_d = S_DATA;
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                if (idx_inc_s == len_q) state_d = S_FINAL;
                else                    state_d = S_DATA;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept_s) begin
                    if (rx_data_i == sum_q) state_d = S_DONE;
                    else                    state_d = S_ERR;
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_CHK;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        hold_d  = ~((state_d == S_IDLE) | (state_d == S_DONE) | (state_d == S_ERR));
        ready_d = hold_d & (state_d != S_WRITE);
    end

    // FSM state, registered outputs and datapath
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            len_hi_q     <= 8'd0;
            len_q        <= '0;
            idx_q        <= '0;
            shift_q      <= 24'd0;
            byte_cnt_q   <= 2'd0;
            to_cnt_q     <= '0;
            w_rom_data_q <= 32'd0;
            w_rom_addr_q <= '0;
            rx_ready_q   <= 1'b0;
            en_w_rom_q   <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            rx_ready_q <= ready_d;
            cpu_hold_q <= hold_d;
            en_w_rom_q <= (state_d == S_WRITE);
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
            if ((state_d == S_LEN_HI) && (state_q != S_LEN_HI)) begin
                to_cnt_q   <= '0;
                idx_q      <= '0;
                byte_cnt_q <= 2'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
                sum_q      <= 8'd0;
`endif
            end else begin
                // The idle counter only runs while a byte could be taken
                if (accept_s)        to_cnt_q <= '0;
                else if (rx_ready_q) to_cnt_q <= to_cnt_q + TO_W'(1);
                case (state_q)
                    S_LEN_HI: if (accept_s) len_hi_q <= rx_data_i;
                    S_LEN_LO: if (accept_s) len_q <= ADDR_W'(hdr_s);
                    S_DATA: begin
                        if (accept_s) begin
                            shift_q    <= {shift_q[15:0], rx_data_i};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                            sum_q      <= sum_q + rx_data_i;
`endif
                            if (byte_cnt_q == 2'd3) begin
                                w_rom_data_q <= {shift_q, rx_data_i};
                                w_rom_addr_q <= idx_q;
                            end
                        end
                    end
                    S_WRITE: idx_q <= idx_inc_s;
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready_o = rx_ready_q;
    assign w_rom_data = w_rom_data_q;
    assign w_rom_addr = w_rom_addr_q;
    assign en_w_rom   = en_w_rom_q;
    assign cpu_hold_o = cpu_hold_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: behavioural frame model checked every cycle, plus literal scenario checks.
module tb_rom_loader;
    localparam int ADDR_W = 16;
    localparam int MAXW   = 1024;
    localparam int TO     = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready_o, en_w_rom, cpu_hold_o, done_o, err_o;
    logic [31:0]       w_rom_data;
    logic [ADDR_W-1:0] w_rom_addr;

    rom_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .rx_data_i(rx_data),
        .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o), .w_rom_data(w_rom_data),
        .w_rom_addr(w_rom_addr), .en_w_rom(en_w_rom), .cpu_hold_o(cpu_hold_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [52:0] outs();
        return {en_w_rom, rx_ready_o, cpu_hold_o, done_o, err_o, w_rom_addr, w_rom_data};
    endfunction

    // Behavioural model: frame position counting, not state encoding
    int          cyc = 0, last_acc_cyc = 0;
    bit          m_busy = 0, m_done = 0, m_err = 0, m_wr = 0, m_chk = 0;
    logic [15:0] m_addr = 16'd0;
    logic [31:0] m_data = 32'd0, m_word = 32'd0;
    logic [7:0]  m_hi = 8'd0, m_sum = 8'd0;
    int          m_nacc = 0, m_n = 0, m_idle = 0;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_wr = 0; m_chk = 0;
        m_addr = 16'd0; m_data = 32'd0; m_word = 32'd0;
        m_nacc = 0; m_n = 0; m_idle = 0; m_sum = 8'd0;
    endtask

    task automatic finish_load();
`ifdef ROM_LOADER_CHECKSUM_EN
        m_chk = 1;
`else
        m_busy = 0; m_done = 1;
`endif
    endtask

    task automatic model_step();
        bit acc;
        int k;
        cyc++;
        acc = rx_valid && m_busy && !m_wr;
        if (acc) last_acc_cyc = cyc;
        if (!m_busy) begin
            m_wr = 0;
            if (start_i) begin
                m_busy = 1; m_done = 0; m_err = 0; m_nacc = 0; m_idle = 0; m_sum = 8'd0; m_chk = 0;
            end
        end else if (m_wr) begin
            m_wr = 0;
            if (int'(m_addr) + 1 == m_n) finish_load();
        end else if (acc) begin
            m_idle = 0;
            if (m_chk) begin
                m_busy = 0; m_chk = 0;
                if (rx_data == m_sum) m_done = 1; else m_err = 1;
            end else if (m_nacc == 0) begin
                m_hi = rx_data;
            end else if (m_nacc == 1) begin
                m_n = int'(m_hi) * 256 + int'(rx_data);
                if (m_n == 0) finish_load();
                else if (m_n > MAXW) begin m_busy = 0; m_err = 1; end
            end else begin
                k = m_nacc - 2;
                m_sum = m_sum + rx_data;
                m_word = (m_word << 8) | 32'(rx_data);
                if (k % 4 == 3) begin m_wr = 1; m_addr = 16'(k / 4); m_data = m_word; end
            end
            m_nacc++;
        end else begin
            m_idle++;
            if (m_idle == TO) begin m_busy = 0; m_err = 1; end
        end
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];

    // Compare process: every cycle, all outputs against the model
    initial begin : compare_proc
        forever begin
            @(negedge clk);
            check("cycle_outputs", outs(),
                  {m_wr, m_busy & ~m_wr, m_busy, m_done, m_err, m_addr, m_data});
            if (en_w_rom) begin
                wr_addr_q.push_back(w_rom_addr);
                wr_data_q.push_back(w_rom_data);
                wr_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_log();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit spur);
        int n;
        rx_valid = 1'b0;
        if (spur) begin start_i = 1'b1; @(negedge clk); start_i = 1'b0; end
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready_o && n < 50) begin @(negedge clk); n++; end
        check("rx_ready_wait", rx_ready_o, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] fr[$], input int gapmax, input bit spur);
        foreach (fr[i])
            send_byte(fr[i], $urandom_range(0, gapmax), spur && ($urandom_range(0, 3) == 0));
    endtask

    task automatic build_frame(input int n, input logic [7:0] pay[$], output logic [7:0] fr[$]);
        logic [15:0] n16;
        logic [7:0]  s;
        n16 = 16'(n);
        s = 8'd0;
        fr.delete();
        fr.push_back(n16[15:8]);
        fr.push_back(n16[7:0]);
        foreach (pay[i]) begin fr.push_back(pay[i]); s = s + pay[i]; end
`ifdef ROM_LOADER_CHECKSUM_EN
        fr.push_back(s);
`endif
    endtask

    task automatic load_lit(input logic [255:0] v, input int nb, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < nb; i++) q.push_back(v[8*(nb-1-i) +: 8]);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done_o || err_o) && n < 100) begin @(negedge clk); n++; end
        check("load_finished", done_o | err_o, 1'b1);
    endtask

    logic [7:0] fr[$];
    logic [7:0] pay[$];

    initial begin : main_proc
        int n, d;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 53'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // N=2 literal frame
        clear_log();
        pulse_start();
        load_lit(256'h0002DEADBEEF01234567, 10, fr);
`ifdef ROM_LOADER_CHECKSUM_EN
        fr.push_back(8'h08);
`endif
        send_bytes(fr, 0, 0);
        wait_end();
        check("n2_writes", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("n2_addr0", wr_addr_q[0], 16'd0);
            check("n2_data0", wr_data_q[0], 32'hDEADBEEF);
            check("n2_addr1", wr_addr_q[1], 16'd1);
            check("n2_data1", wr_data_q[1], 32'h01234567);
        end
        check("n2_done", done_o, 1'b1);
        check("n2_hold", cpu_hold_o, 1'b0);

        // Empty load
        clear_log();
        pulse_start();
        pay.delete();
        build_frame(0, pay, fr);
        send_bytes(fr, 1, 0);
        wait_end();
        check("n0_done", done_o, 1'b1);
        check("n0_writes", wr_addr_q.size(), 0);

        // Count one above the ROM depth
        clear_log();
        pulse_start();
        load_lit(256'h0401, 2, fr);
        send_bytes(fr, 0, 0);
        wait_end();
        check("over_err", err_o, 1'b1);
        check("over_writes", wr_addr_q.size(), 0);

        // Continuous valid: 5 cycles per word
        clear_log();
        pulse_start();
        pay.delete();
        for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
        build_frame(3, pay, fr);
        send_bytes(fr, 0, 0);
        wait_end();
        check("bp_writes", wr_cyc_q.size(), 3);
        if (wr_cyc_q.size() == 3) begin
            check("bp_gap0", wr_cyc_q[1] - wr_cyc_q[0], 5);
            check("bp_gap1", wr_cyc_q[2] - wr_cyc_q[1], 5);
        end

        // Timeout after 3 payload bytes
        clear_log();
        pulse_start();
        load_lit(256'h0001AABBCC, 5, fr);
        send_bytes(fr, 1, 0);
        n = 0;
        while (!err_o && n < TO + 20) begin @(negedge clk); n++; end
        check("to_err", err_o, 1'b1);
        check("to_latency", cyc - last_acc_cyc, TO);
        check("to_writes", wr_addr_q.size(), 0);

`ifdef ROM_LOADER_CHECKSUM_EN
        clear_log();
        pulse_start();
        load_lit(256'h0001AABBCCDD0E, 7, fr);
        send_bytes(fr, 0, 0);
        wait_end();
        check("chk_ok_done", done_o, 1'b1);
        clear_log();
        pulse_start();
        load_lit(256'h0001AABBCCDD0F, 7, fr);
        send_bytes(fr, 0, 0);
        wait_end();
        check("chk_bad_err", err_o, 1'b1);
        check("chk_bad_writes", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) check("chk_bad_data", wr_data_q[0], 32'hAABBCCDD);
`endif

        // Random frames with gaps, spurious start pulses and bytes offered while idle
        for (int r = 0; r < 20; r++) begin
            clear_log();
            n = $urandom_range(1, 6);
            pay.delete();
            for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
            build_frame(n, pay, fr);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (r % 4 == 1) begin
                rx_valid = 1'b1; rx_data = 8'($urandom);
                @(negedge clk);
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0; rx_valid = 1'b0;
            end else begin
                pulse_start();
            end
            send_bytes(fr, $urandom_range(0, 3), (r % 3 == 0));
            wait_end();
            check("rand_done", done_o, 1'b1);
            check("rand_writes", wr_addr_q.size(), n);
        end

        // Largest accepted count
        clear_log();
        pulse_start();
        pay.delete();
        for (int i = 0; i < 4 * MAXW; i++) pay.push_back(8'($urandom));
        build_frame(MAXW, pay, fr);
        send_bytes(fr, 0, 0);
        wait_end();
        check("max_done", done_o, 1'b1);
        check("max_writes", wr_addr_q.size(), MAXW);
        if (wr_addr_q.size() == MAXW) check("max_last_addr", wr_addr_q[MAXW-1], 16'(MAXW - 1));

        // Asynchronous reset in the middle of a payload
        clear_log();
        pulse_start();
        load_lit(256'h00041122334455, 7, fr);
        send_bytes(fr, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", outs(), 53'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        pulse_start();
        load_lit(256'h000112345678, 6, fr);
`ifdef ROM_LOADER_CHECKSUM_EN
        fr.push_back(8'h14);
`endif
        send_bytes(fr, 1, 0);
        wait_end();
        check("post_reset_done", done_o, 1'b1);
        check("post_reset_writes", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("post_reset_addr", wr_addr_q[0], 16'd0);
            check("post_reset_data", wr_data_q[0], 32'h12345678);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
